// File: rtl/ysyx_23060124_axi_sram.sv
// AXI4-Lite slave SRAM for IFU fetches and arbitrated data accesses.
// Responses are delayed by a fixed count or a 4-bit LFSR value.
module ysyx_23060124_axi_sram #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    DEPTH       = 4096,
    parameter int                    FIXED_DELAY = 0,
    parameter bit                    USE_LFSR    = 1'b1
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  ifu_rst,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY
);

    localparam int                    IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH);

    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_HALF = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_DECERR = 2'b11;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            r_state, w_state;
    logic [3:0]            lfsr, r_cnt, w_cnt, r_delay, w_delay;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr, r_src;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            w_strb;
    logic                  ar_go, aw_go, w_go, pair_go, r_fire, w_commit;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[1] ^ s[0], s[3:1]};
    endfunction

    always_comb begin
        ar_go    = (r_state == R_IDLE) && S_AXI_ARREADY && S_AXI_ARVALID;
        aw_go    = S_AXI_AWREADY && S_AXI_AWVALID;
        w_go     = S_AXI_WREADY && S_AXI_WVALID;
        // In W_HALF only the missing channel is ready, so any handshake completes the pair.
        pair_go  = ((w_state == W_IDLE) && aw_go && w_go) ||
                   ((w_state == W_HALF) && (aw_go || w_go));
        r_delay  = USE_LFSR ? lfsr : 4'(FIXED_DELAY);
        w_delay  = USE_LFSR ? (ar_go ? lfsr_step(lfsr) : lfsr) : 4'(FIXED_DELAY);
        r_src    = (r_state == R_IDLE) ? S_AXI_ARADDR : r_addr;
        r_fire   = (ar_go && (r_delay == 4'd0)) || ((r_state == R_WAIT) && (r_cnt == 4'd1));
        w_commit = (w_state == W_WAIT) && (w_cnt == 4'd0);
    end

    always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
        if (!ifu_rst) begin
            r_state       <= R_IDLE;
            r_addr        <= '0;
            r_cnt         <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_go) begin
                        S_AXI_ARREADY <= 1'b0;
                        r_addr        <= S_AXI_ARADDR;
                        r_cnt         <= r_delay;
                        r_state       <= (r_delay == 4'd0) ? R_RESP : R_WAIT;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd1) r_state <= R_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
            if (r_fire) begin
                S_AXI_RVALID <= 1'b1;
                if (in_range(r_src)) begin
                    S_AXI_RDATA <= mem[word_idx(r_src)];
                    S_AXI_RRESP <= RESP_OKAY;
                end else begin
                    S_AXI_RDATA <= '0;
                    S_AXI_RRESP <= RESP_DECERR;
                end
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
        if (!ifu_rst) begin
            w_state       <= W_IDLE;
            w_addr        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            w_cnt         <= '0;
            lfsr          <= 4'b1001;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= '0;
        end else begin
            if (aw_go) w_addr <= S_AXI_AWADDR;
            if (w_go) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            case (w_state)
                W_IDLE: begin
                    if (pair_go) begin
                        {S_AXI_AWREADY, S_AXI_WREADY} <= 2'b00;
                        w_cnt   <= w_delay;
                        w_state <= W_WAIT;
                    end else if (aw_go) begin
                        {S_AXI_AWREADY, S_AXI_WREADY} <= 2'b01;
                        w_state <= W_HALF;
                    end else if (w_go) begin
                        {S_AXI_AWREADY, S_AXI_WREADY} <= 2'b10;
                        w_state <= W_HALF;
                    end else begin
                        {S_AXI_AWREADY, S_AXI_WREADY} <= 2'b11;
                    end
                end
                W_HALF: begin
                    if (pair_go) begin
                        {S_AXI_AWREADY, S_AXI_WREADY} <= 2'b00;
                        w_cnt   <= w_delay;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd0) begin
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BRESP  <= in_range(w_addr) ? RESP_OKAY : RESP_DECERR;
                        w_state      <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                default: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        {S_AXI_AWREADY, S_AXI_WREADY} <= 2'b11;
                        w_state <= W_IDLE;
                    end
                end
            endcase
            // A read and a write pair accepted together consume two consecutive values.
            if (ar_go && pair_go)      lfsr <= lfsr_step(lfsr_step(lfsr));
            else if (ar_go || pair_go) lfsr <= lfsr_step(lfsr);
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (w_commit && in_range(w_addr)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[word_idx(w_addr)][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_axi_sram.sv
// Directed bench: instance 0 fixed delay 0, instance 1 fixed delay 3, instance 2 LFSR delay.
module tb_ysyx_23060124_axi_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr [3], rdata [3], awaddr [3], wdata [3];
    logic        arvalid [3], arready [3], rvalid [3], rready [3];
    logic        awvalid [3], awready [3], wvalid [3], wready [3];
    logic        bvalid [3], bready [3];
    logic [1:0]  rresp [3], bresp [3];
    logic [3:0]  wstrb [3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_23060124_axi_sram #(
            .FIXED_DELAY((g == 1) ? 3 : 0),
            .USE_LFSR   (g == 2)
        ) u_dut (
            .M_AXI_ACLK   (clk),
            .ifu_rst      (rst_n),
            .S_AXI_ARADDR (araddr[g]),
            .S_AXI_ARVALID(arvalid[g]),
            .S_AXI_ARREADY(arready[g]),
            .S_AXI_RDATA  (rdata[g]),
            .S_AXI_RRESP  (rresp[g]),
            .S_AXI_RVALID (rvalid[g]),
            .S_AXI_RREADY (rready[g]),
            .S_AXI_AWADDR (awaddr[g]),
            .S_AXI_AWVALID(awvalid[g]),
            .S_AXI_AWREADY(awready[g]),
            .S_AXI_WDATA  (wdata[g]),
            .S_AXI_WSTRB  (wstrb[g]),
            .S_AXI_WVALID (wvalid[g]),
            .S_AXI_WREADY (wready[g]),
            .S_AXI_BRESP  (bresp[g]),
            .S_AXI_BVALID (bvalid[g]),
            .S_AXI_BREADY (bready[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts edges from the AR handshake edge to RVALID; 0 means no response.
    task automatic read_txn(input int i, input logic [31:0] a,
                            output logic [31:0] d, output logic [1:0] r, output int lat);
        int n = 0;
        araddr[i] = a;
        arvalid[i] = 1'b1;
        while (!arready[i] && n < 20) begin tick(); n++; end
        tick();
        arvalid[i] = 1'b0;
        lat = 1;
        while (!rvalid[i] && lat < 40) begin tick(); lat++; end
        if (!rvalid[i]) lat = 0;
        d = rdata[i];
        r = rresp[i];
        rready[i] = 1'b1;
        tick();
        rready[i] = 1'b0;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: together.
    task automatic write_txn(input int i, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead,
                             output logic [1:0] br, output logic half_low, output logic ok);
        int n = 0;
        awaddr[i] = a;
        wdata[i] = d;
        wstrb[i] = s;
        if (lead >= 0) wvalid[i] = 1'b1;
        if (lead <= 0) awvalid[i] = 1'b1;
        tick();
        wvalid[i] = 1'b0;
        awvalid[i] = 1'b0;
        half_low = (lead > 0) ? !wready[i] : (lead < 0) ? !awready[i] : 1'b1;
        if (lead != 0) begin
            repeat (((lead > 0) ? lead : -lead) - 1) tick();
            if (lead > 0) awvalid[i] = 1'b1;
            else          wvalid[i] = 1'b1;
            tick();
            awvalid[i] = 1'b0;
            wvalid[i] = 1'b0;
        end
        while (!bvalid[i] && n < 40) begin tick(); n++; end
        ok = bvalid[i];
        br = bresp[i];
        bready[i] = 1'b1;
        tick();
        bready[i] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({arready[i], awready[i], wready[i], rvalid[i], bvalid[i]} !== 5'b00000) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%b want=00000", i,
                         {arready[i], awready[i], wready[i], rvalid[i], bvalid[i]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({arready[i], awready[i], wready[i], rvalid[i], bvalid[i], rdata[i], rresp[i], bresp[i]}
                !== {5'b11100, 32'h0, 2'b00, 2'b00}) begin
                bad++;
                $display("FAIL reset_release[%0d] got=%b/%h/%b/%b want=11100/00000000/00/00", i,
                         {arready[i], awready[i], wready[i], rvalid[i], bvalid[i]},
                         rdata[i], rresp[i], bresp[i]);
            end
        end
    endtask

    task automatic test_fixed0();
        logic [31:0] d; logic [1:0] r, br; logic hl, ok; int lat;
        write_txn(0, 32'h8000_0000, 32'h0000_0413, 4'hF, 0, br, hl, ok);
        total++;
        if ({ok, br} !== 3'b100) begin bad++; $display("FAIL fixed0_wr got=%b want=100", {ok, br}); end
        read_txn(0, 32'h8000_0000, d, r, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL fixed0_lat got=%0d want=1", lat); end
        total++;
        if ({d, r} !== {32'h0000_0413, 2'b00}) begin
            bad++; $display("FAIL fixed0_data got=%h/%b want=00000413/00", d, r);
        end
    endtask

    task automatic test_delay3();
        logic [31:0] d0; logic [1:0] r0, br; logic hl, ok, arhi, stable; int lat;
        write_txn(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 0, br, hl, ok);
        rready[1] = 1'b1;
        tick(); tick();
        rready[1] = 1'b0;
        total++;
        if ({rvalid[1], arready[1]} !== 2'b01) begin
            bad++; $display("FAIL idle_rready got=%b want=01", {rvalid[1], arready[1]});
        end
        araddr[1] = 32'h8000_0020;
        arvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0;
        arhi = 1'b0;
        lat = 1;
        while (!rvalid[1] && lat < 20) begin arhi |= arready[1]; tick(); lat++; end
        d0 = rdata[1];
        r0 = rresp[1];
        stable = rvalid[1];
        repeat (5) begin
            tick();
            if (rdata[1] !== d0 || rresp[1] !== r0 || !rvalid[1]) stable = 1'b0;
            arhi |= arready[1];
        end
        rready[1] = 1'b1;
        #1;
        if (rdata[1] !== d0 || rresp[1] !== r0 || !rvalid[1]) stable = 1'b0;
        tick();
        rready[1] = 1'b0;
        total++;
        if (lat !== 4) begin bad++; $display("FAIL delay3_lat got=%0d want=4", lat); end
        total++;
        if ({d0, r0} !== {32'h1234_5678, 2'b00}) begin
            bad++; $display("FAIL delay3_data got=%h/%b want=12345678/00", d0, r0);
        end
        total++;
        if ({stable, arhi} !== 2'b10) begin
            bad++; $display("FAIL delay3_stall got=stable%b/arready%b want=stable1/arready0", stable, arhi);
        end
        total++;
        if ({rvalid[1], arready[1]} !== 2'b01) begin
            bad++; $display("FAIL delay3_done got=%b want=01", {rvalid[1], arready[1]});
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r, br; logic hl, ok; int lat;
        write_txn(0, 32'h8000_0010, 32'h0, 4'hF, 0, br, hl, ok);
        write_txn(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0101, 2, br, hl, ok);
        total++;
        if ({ok, hl, br} !== 4'b1100) begin
            bad++; $display("FAIL strb_w_first got=%b want=1100", {ok, hl, br});
        end
        read_txn(0, 32'h8000_0010, d, r, lat);
        total++;
        if ({d, r} !== {32'h00AD_00EF, 2'b00}) begin
            bad++; $display("FAIL strb_w_first_data got=%h/%b want=00ad00ef/00", d, r);
        end
        write_txn(0, 32'h8000_0010, 32'hCAFE_F00D, 4'b1010, -1, br, hl, ok);
        total++;
        if ({ok, hl, br} !== 4'b1100) begin
            bad++; $display("FAIL strb_aw_first got=%b want=1100", {ok, hl, br});
        end
        read_txn(0, 32'h8000_0010, d, r, lat);
        total++;
        if (d !== 32'hCAAD_F0EF) begin
            bad++; $display("FAIL strb_aw_first_data got=%h want=caadf0ef", d);
        end
    endtask

    task automatic test_decerr();
        logic [31:0] d; logic [1:0] r, br; logic hl, ok; int lat;
        read_txn(0, 32'h7FFF_FFFC, d, r, lat);
        total++;
        if ({d, r, lat} !== {32'h0, 2'b11, 32'd1}) begin
            bad++; $display("FAIL decerr_below got=%h/%b/%0d want=00000000/11/1", d, r, lat);
        end
        read_txn(0, 32'h8000_4000, d, r, lat);
        total++;
        if ({d, r} !== {32'h0, 2'b11}) begin
            bad++; $display("FAIL decerr_above got=%h/%b want=00000000/11", d, r);
        end
        write_txn(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, br, hl, ok);
        total++;
        if ({ok, br} !== 3'b111) begin bad++; $display("FAIL decerr_wr got=%b want=111", {ok, br}); end
        read_txn(0, 32'h8000_0000, d, r, lat);
        total++;
        if (d !== 32'h0000_0413) begin bad++; $display("FAIL decerr_no_alias got=%h want=00000413", d); end
        write_txn(0, 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 0, br, hl, ok);
        read_txn(0, 32'h8000_3FFF, d, r, lat);
        total++;
        if ({br, d, r} !== {2'b00, 32'hA5A5_5A5A, 2'b00}) begin
            bad++; $display("FAIL last_word got=%b/%h/%b want=00/a5a55a5a/00", br, d, r);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic [1:0] r, br; logic hl, ok; int lat, n;
        write_txn(0, 32'h8000_0040, 32'h1111_1111, 4'hF, 0, br, hl, ok);
        awaddr[0] = 32'h8000_0040; wdata[0] = 32'h2222_2222; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        araddr[0] = 32'h8000_0040; arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        total++;
        if ({rvalid[0], rdata[0]} !== {1'b1, 32'h1111_1111}) begin
            bad++; $display("FAIL collision_old got=%b/%h want=1/11111111", rvalid[0], rdata[0]);
        end
        rready[0] = 1'b1;
        tick();
        rready[0] = 1'b0;
        n = 0;
        while (!bvalid[0] && n < 20) begin tick(); n++; end
        br = bresp[0]; ok = bvalid[0];
        bready[0] = 1'b1;
        tick();
        bready[0] = 1'b0;
        read_txn(0, 32'h8000_0040, d, r, lat);
        total++;
        if ({ok, br, d} !== {3'b100, 32'h2222_2222}) begin
            bad++; $display("FAIL collision_new got=%b/%h want=100/22222222", {ok, br}, d);
        end
    endtask

    task automatic test_lfsr();
        logic [31:0] d; logic [1:0] r; int lat, rlat;
        int exp_lat [4] = '{10, 13, 7, 12};
        logic rdone, bdone;
        for (int k = 0; k < 4; k++) begin
            read_txn(2, 32'h8000_0000 + 32'(4 * k), d, r, lat);
            total++;
            if (lat !== exp_lat[k] || r !== 2'b00) begin
                bad++; $display("FAIL lfsr_read%0d got=lat%0d/%b want=lat%0d/00", k, lat, r, exp_lat[k]);
            end
        end
        araddr[2] = 32'h8000_0100; arvalid[2] = 1'b1;
        awaddr[2] = 32'h8000_0100; wdata[2] = 32'h5555_AAAA; wstrb[2] = 4'hF;
        awvalid[2] = 1'b1; wvalid[2] = 1'b1;
        tick();
        arvalid[2] = 1'b0; awvalid[2] = 1'b0; wvalid[2] = 1'b0;
        rdone = 1'b0; bdone = 1'b0; rlat = 0;
        for (int c = 1; c < 60 && !(rdone && bdone); c++) begin
            if (rvalid[2] && !rdone) begin rlat = c; rready[2] = 1'b1; rdone = 1'b1; end
            else rready[2] = 1'b0;
            if (bvalid[2] && !bdone) begin bready[2] = 1'b1; bdone = 1'b1; end
            else bready[2] = 1'b0;
            tick();
        end
        rready[2] = 1'b0; bready[2] = 1'b0;
        total++;
        if ({rdone, bdone, rlat} !== {2'b11, 32'd6}) begin
            bad++; $display("FAIL lfsr_dual got=%b/lat%0d want=11/lat6", {rdone, bdone}, rlat);
        end
        read_txn(2, 32'h8000_0100, d, r, lat);
        total++;
        if ({lat, d} !== {32'd14, 32'h5555_AAAA}) begin
            bad++; $display("FAIL lfsr_after_dual got=lat%0d/%h want=lat14/5555aaaa", lat, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; logic pre, spurious; int lat;
        araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1;
        araddr[1] = 32'h8000_0020; arvalid[1] = 1'b1;
        tick();
        arvalid[0] = 1'b0; arvalid[1] = 1'b0;
        tick();
        pre = rvalid[0] && !rvalid[1];
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({pre, rvalid[0], rvalid[1], arready[1]} !== 4'b1000) begin
            bad++; $display("FAIL reset_mid_async got=%b want=1000", {pre, rvalid[0], rvalid[1], arready[1]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        spurious = 1'b0;
        total++;
        if (arready[1] !== 1'b1) begin bad++; $display("FAIL reset_mid_arready got=%b want=1", arready[1]); end
        repeat (5) begin spurious |= rvalid[1]; tick(); end
        read_txn(1, 32'h8000_0020, d, r, lat);
        total++;
        if ({spurious, lat, d, r} !== {1'b0, 32'd4, 32'h1234_5678, 2'b00}) begin
            bad++; $display("FAIL reset_mid_after got=%b/lat%0d/%h/%b want=0/lat4/12345678/00",
                            spurious, lat, d, r);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
            awaddr[i] = '0; awvalid[i] = 1'b0; wdata[i] = '0; wstrb[i] = '0;
            wvalid[i] = 1'b0; bready[i] = 1'b0;
        end
        test_reset();
        test_fixed0();
        test_delay3();
        test_strobe();
        test_decerr();
        test_collision();
        test_lfsr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
